// File: rtl/alarm_pkg.sv
// Shared types and BCD helpers for the alarm setpoint / ringing controller.
package alarm_pkg;

    typedef enum logic [2:0] {
        StDisarmed,
        StSet,
        StArmed,
        StRinging,
        StSnoozed
    } state_e;

    localparam logic [7:0] BcdMax = 8'h59;

    function automatic logic [7:0] bcd_inc_mod60(input logic [7:0] bcd);
        if (bcd >= BcdMax) begin
            return 8'h00;
        end else if (bcd[3:0] == 4'd9) begin
            return {bcd[7:4] + 4'd1, 4'd0};
        end else begin
            return {bcd[7:4], bcd[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [7:0] bcd_add_mod60(input logic [7:0] a, input logic [7:0] b);
        logic [6:0] sum;
        sum = 7'(a[7:4] * 10 + a[3:0]) + 7'(b[7:4] * 10 + b[3:0]);
        if (sum >= 7'd60) begin
            sum = sum - 7'd60;
        end
        return {4'(sum / 10), 4'(sum % 10)};
    endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Bus between the time counter / buttons / display mux and the alarm controller.
interface alarm_ctrl_if;

    logic       tick_1hz;
    logic [7:0] cur_min_bcd;
    logic [7:0] cur_sec_bcd;
    logic       btn_set;
    logic       btn_arm;
    logic       btn_inc_min;
    logic       btn_inc_sec;
    logic       btn_snooze;
    logic       btn_stop;
    logic [7:0] alarm_min_bcd;
    logic [7:0] alarm_sec_bcd;
    logic       show_alarm;
    logic       armed;
    logic       ringing;
    logic       buzz;

    modport master (
        output tick_1hz, cur_min_bcd, cur_sec_bcd,
        output btn_set, btn_arm, btn_inc_min, btn_inc_sec, btn_snooze, btn_stop,
        input  alarm_min_bcd, alarm_sec_bcd, show_alarm, armed, ringing, buzz
    );

    modport slave (
        input  tick_1hz, cur_min_bcd, cur_sec_bcd,
        input  btn_set, btn_arm, btn_inc_min, btn_inc_sec, btn_snooze, btn_stop,
        output alarm_min_bcd, alarm_sec_bcd, show_alarm, armed, ringing, buzz
    );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability counter; one-cycle pulse on a debounced press.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk50,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d    = db_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CntLast) begin
                db_d    = sync2_q;
                press_d = sync2_q;  // only the rising transition pulses
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm setpoint, match detection and ringing/snooze/timeout FSM with registered outputs.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RING_TIMEOUT_S  = 60,
    parameter int unsigned SNOOZE_MIN      = 5,
    parameter int unsigned MAX_SNOOZE      = 3
) (
    input  logic         clk50,
    input  logic         reset,
    alarm_ctrl_if.slave  bus
);

    localparam int unsigned TmrW = $clog2(RING_TIMEOUT_S + 1);
    localparam int unsigned SnzW = $clog2(MAX_SNOOZE + 1);
    localparam logic [7:0]  SnoozeBcd = {4'(SNOOZE_MIN / 10), 4'(SNOOZE_MIN % 10)};

    logic [5:0] raw, press;
    assign raw = {bus.btn_stop, bus.btn_snooze, bus.btn_inc_sec,
                  bus.btn_inc_min, bus.btn_arm, bus.btn_set};

    for (genvar i = 0; i < 6; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk50  (clk50),
            .reset  (reset),
            .btn_raw(raw[i]),
            .press  (press[i])
        );
    end

    logic set_p, arm_p, inc_min_p, inc_sec_p, snooze_p, stop_p;
    assign {stop_p, snooze_p, inc_sec_p, inc_min_p, arm_p, set_p} = press;

    state_e          state_q, state_d;
    logic [7:0]      alarm_min_q, alarm_min_d, alarm_sec_q, alarm_sec_d;
    logic [7:0]      snz_min_q, snz_min_d, snz_sec_q, snz_sec_d;
    logic [SnzW-1:0] snz_cnt_q, snz_cnt_d;
    logic [TmrW-1:0] timer_q, timer_d;
    logic            beep_q, beep_d, use_snz_q, use_snz_d;
    logic            match_q, match_prev_q, rise;
    logic            show_q, armed_q, ringing_q, buzz_q;
    logic [15:0]     target;

    assign target = use_snz_q ? {snz_min_q, snz_sec_q} : {alarm_min_q, alarm_sec_q};
    assign rise   = match_q & ~match_prev_q;

    always_comb begin
        state_d     = state_q;
        alarm_min_d = alarm_min_q;
        alarm_sec_d = alarm_sec_q;
        snz_min_d   = snz_min_q;
        snz_sec_d   = snz_sec_q;
        snz_cnt_d   = snz_cnt_q;
        timer_d     = timer_q;
        beep_d      = beep_q;
        use_snz_d   = use_snz_q;
        unique case (state_q)
            StDisarmed: begin
                if (set_p)      state_d = StSet;
                else if (arm_p) state_d = StArmed;
            end
            StSet: begin
                if (set_p) begin
                    state_d = StDisarmed;
                end else begin
                    if (inc_min_p) alarm_min_d = bcd_inc_mod60(alarm_min_q);
                    if (inc_sec_p) alarm_sec_d = bcd_inc_mod60(alarm_sec_q);
                end
            end
            StArmed: begin
                if (arm_p) begin
                    state_d = StDisarmed;
                end else if (set_p) begin
                    state_d = StSet;
                end else if (rise) begin
                    state_d   = StRinging;
                    snz_cnt_d = '0;
                    timer_d   = '0;
                    beep_d    = 1'b1;
                end
            end
            StRinging: begin
                if (stop_p) begin
                    state_d   = StArmed;
                    use_snz_d = 1'b0;
                end else if (snooze_p && (snz_cnt_q < SnzW'(MAX_SNOOZE))) begin
                    state_d   = StSnoozed;
                    snz_min_d = bcd_add_mod60(bus.cur_min_bcd, SnoozeBcd);
                    snz_sec_d = bus.cur_sec_bcd;
                    snz_cnt_d = snz_cnt_q + SnzW'(1);
                    use_snz_d = 1'b1;
                end else if (bus.tick_1hz) begin
                    if (timer_q == TmrW'(RING_TIMEOUT_S - 1)) begin
                        state_d   = StArmed;
                        use_snz_d = 1'b0;
                    end else begin
                        timer_d = timer_q + TmrW'(1);
                        beep_d  = ~beep_q;
                    end
                end
            end
            StSnoozed: begin
                if (stop_p) begin
                    state_d   = StArmed;
                    use_snz_d = 1'b0;
                end else if (arm_p) begin
                    state_d   = StDisarmed;
                    use_snz_d = 1'b0;
                end else if (rise) begin
                    state_d = StRinging;
                    timer_d = '0;
                    beep_d  = 1'b1;
                end
            end
            default: state_d = StDisarmed;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q      <= StDisarmed;
            alarm_min_q  <= 8'h00;
            alarm_sec_q  <= 8'h00;
            snz_min_q    <= 8'h00;
            snz_sec_q    <= 8'h00;
            snz_cnt_q    <= '0;
            timer_q      <= '0;
            beep_q       <= 1'b0;
            use_snz_q    <= 1'b0;
            match_q      <= 1'b0;
            match_prev_q <= 1'b0;
            show_q       <= 1'b0;
            armed_q      <= 1'b0;
            ringing_q    <= 1'b0;
            buzz_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_min_q  <= alarm_min_d;
            alarm_sec_q  <= alarm_sec_d;
            snz_min_q    <= snz_min_d;
            snz_sec_q    <= snz_sec_d;
            snz_cnt_q    <= snz_cnt_d;
            timer_q      <= timer_d;
            beep_q       <= beep_d;
            use_snz_q    <= use_snz_d;
            match_q      <= (target == {bus.cur_min_bcd, bus.cur_sec_bcd});
            match_prev_q <= match_q;
            show_q       <= (state_d == StSet);
            armed_q      <= (state_d == StArmed) || (state_d == StRinging) ||
                            (state_d == StSnoozed);
            ringing_q    <= (state_d == StRinging);
            buzz_q       <= (state_d == StRinging) && beep_d;
        end
    end

    assign bus.alarm_min_bcd = alarm_min_q;
    assign bus.alarm_sec_bcd = alarm_sec_q;
    assign bus.show_alarm    = show_q;
    assign bus.armed         = armed_q;
    assign bus.ringing       = ringing_q;
    assign bus.buzz          = buzz_q;

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm setpoint and ringing controller for the MM:SS alarm clock. Sits directly downstream of the time counter: consumes its BCD minute/second digits and a 1 Hz tick, holds a user-set alarm time, and detects the match. It also runs the ringing/snooze/timeout state machine and drives the buzzer LED plus a display-select flag for the 7-segment mux.

## Interface
- DEBOUNCE_CYCLES, 500000: clk50 cycles a button must stay stable to register (10 ms at 50 MHz).
- RING_TIMEOUT_S, 60: tick_1hz pulses in RINGING before auto-stop.
- SNOOZE_MIN, 5: minutes added to the current time on snooze (1..59).
- MAX_SNOOZE, 3: snoozes allowed per alarm event.
- clk50 in 1: system clock, 50 MHz.
- reset in 1: synchronous, active-high.
- tick_1hz in 1: one-cycle enable, once per second, from the time counter.
- cur_min_bcd in 8: current minutes, two BCD digits, 00..59.
- cur_sec_bcd in 8: current seconds, two BCD digits, 00..59.
- btn_set, btn_arm, btn_inc_min, btn_inc_sec, btn_snooze, btn_stop in 1 each: raw asynchronous push buttons, active-high.
- alarm_min_bcd out 8: stored alarm minutes (BCD).
- alarm_sec_bcd out 8: stored alarm seconds (BCD).
- show_alarm out 1: high in SET; the mux then displays alarm_* instead of cur_*.
- armed out 1: high in ARMED, RINGING, SNOOZED.
- ringing out 1: high in RINGING.
- buzz out 1: ringing AND beep phase; the beep phase toggles on each tick_1hz.

## Operation
- Each button passes through a 2-FF synchroniser, then a debounce counter. It yields a one-cycle press pulse on the debounced rising edge. Release produces no pulse.
- States: DISARMED, SET, ARMED, RINGING, SNOOZED. Reset state is DISARMED.
- DISARMED: set -> SET; arm -> ARMED.
- SET: inc_min increments alarm minutes; inc_sec increments alarm seconds. Both use BCD arithmetic, wrap 59 -> 00, and never carry between fields. set -> DISARMED. All other buttons are ignored.
- ARMED:
  - arm -> DISARMED; set -> SET.
  - When the match rises (target == cur, previous cycle not equal): -> RINGING, snooze_cnt cleared, ring_timer cleared, beep phase set to 1.
  - Target is alarm_* on the first ring, and snooze_* after a snooze.
- RINGING (priority stop > snooze > timeout):
  - stop -> ARMED with target restored to alarm_*.
  - snooze with snooze_cnt < MAX_SNOOZE -> SNOOZED: snooze_min = (cur_min + SNOOZE_MIN) mod 60 in BCD, snooze_sec = cur_sec, snooze_cnt + 1.
  - snooze at the limit is ignored.
  - ring_timer counts tick_1hz; on reaching RING_TIMEOUT_S -> ARMED with target restored.
- SNOOZED:
  - Rising match against snooze_* -> RINGING with ring_timer cleared.
  - stop -> ARMED with target restored.
  - arm -> DISARMED.
- Match detection uses rising-edge logic only. Stopping while cur still equals target does not re-trigger. The alarm recurs every hour, because the clock wraps at 59:59.
- Match is compared as raw 16-bit equality. The inputs are guaranteed valid BCD by the upstream counter.
- Reset values:
  - alarm_min_bcd = alarm_sec_bcd = 8'h00.
  - show_alarm = armed = ringing = buzz = 0.
  - snooze registers and counters = 0.
  - Debounce state = released.

## Timing
- Button press pulse appears 2 + DEBOUNCE_CYCLES cycles after the raw input settles high. A glitch shorter than DEBOUNCE_CYCLES never pulses.
- State and alarm register updates happen on the clock edge after the press pulse. All outputs are registered, so they change 1 cycle after that.
- Match: cur_* changes on cycle N, which registers the match (match_d) at N+1. ringing rises at N+2.
- tick_1hz and a button event on the same cycle: the button transition wins. ring_timer and beep phase update only if the state remains RINGING.
- reset asserted mid-RINGING: the next edge returns all outputs to reset values. The stored alarm time is cleared too.
- Repeated inc pulses: one increment per pulse. No auto-repeat.

## Structure
- Package alarm_pkg holds:
  - the state enum;
  - the BCD constant 8'h59;
  - a function bcd_inc_mod60(bcd);
  - a function bcd_add_mod60(a, b), used for the snooze target.
- Sub-module button_debounce(clk50, reset, btn_raw, press) is instantiated six times, parameterised by DEBOUNCE_CYCLES.
- The top level holds the FSM, the alarm/snooze registers, the match edge detect and the ring timer.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Set alarm: press set, inc_min ×3, inc_sec ×61, set. Required: alarm = 03:01, with inc_sec wrapping at 59 -> 00. show_alarm high only while in SET.
- Bounce: raw btn_inc_min toggles for 3 cycles, then holds high for 10 cycles. Required: exactly one increment, issued 6 cycles after the input stabilises.
- Ring and stop: alarm 00:05, armed, drive cur 00:04 -> 00:05. Required: ringing rises 2 cycles after the change. buzz toggles with tick_1hz. stop clears ringing while cur is still 00:05, with no re-trigger.
- Snooze wrap: alarm 58:00 ringing; snooze. Required: target 03:00 (BCD wrap) and state SNOOZED. Driving cur = 03:00 re-rings. The fourth snooze press is ignored while ringing stays high.
- Timeout: ringing with no button presses for 60 tick_1hz pulses. Required: the state returns to ARMED with ringing = 0, and the alarm re-rings at the next hourly match.
- Reset and priority: stop and snooze pressed on the same cycle -> ARMED. Reset during RINGING -> all outputs 0 and alarm 00:00 on the next edge.
